// File: rtl/pim_pkg.sv
// Shared definitions for the PIM vector sequencer and its ALU.
// Opcodes are kept 3 bits wide so future tiles can reuse the same decode.
package pim_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 6;
  localparam int LEN_WIDTH_DEF  = ADDR_WIDTH_DEF + 1;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_MAX  = 3'd6,
    OP_COPY = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/pim_alu.sv
// Combinational element-wise ALU; all results wrap to DATA_WIDTH bits,
// MAX compares as signed two's-complement.
module pim_alu
  import pim_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);

  always_comb begin
    y = a;
    case (op_e'(op))
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_MUL:  y = a * b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_MAX:  y = ($signed(a) > $signed(b)) ? a : b;
      OP_COPY: y = a;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/pim_vec_ctrl.sv
// Element-wise vector sequencer over one dual-port BRAM: read A/B, apply ALU,
// write back through port A; the host borrows port B whenever the FSM is idle.
module pim_vec_ctrl
  import pim_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [ADDR_WIDTH-1:0] src_a,
  input  logic [ADDR_WIDTH-1:0] src_b,
  input  logic [ADDR_WIDTH-1:0] dst,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_gnt,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_rvalid,
  output logic                  wea,
  output logic                  web,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] dia,
  output logic [DATA_WIDTH-1:0] dib,
  input  logic [DATA_WIDTH-1:0] doa,
  input  logic [DATA_WIDTH-1:0] dob
);

  state_e                state_reg;
  logic [2:0]            op_reg;
  logic [ADDR_WIDTH-1:0] src_a_reg;
  logic [ADDR_WIDTH-1:0] src_b_reg;
  logic [ADDR_WIDTH-1:0] dst_reg;
  logic [LEN_WIDTH-1:0]  len_reg;
  logic [LEN_WIDTH-1:0]  idx_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  rvalid_reg;
  logic [ADDR_WIDTH-1:0] addra_hold_reg;
  logic [ADDR_WIDTH-1:0] addrb_hold_reg;

  logic [ADDR_WIDTH-1:0] elem_idx;
  logic [DATA_WIDTH-1:0] alu_y;
  logic                  last_elem;

  pim_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .op(op_reg),
    .a (doa),
    .b (dob),
    .y (alu_y)
  );

  // Index never exceeds len-1, so its low bits are the in-vector offset.
  assign elem_idx  = idx_reg[ADDR_WIDTH-1:0];
  assign last_elem = (idx_reg == (len_reg - LEN_WIDTH'(1)));

  // A start in the same cycle takes priority over the host.
  assign host_gnt    = host_req && (state_reg == ST_IDLE) && !start;
  assign host_rdata  = dob;
  assign host_rvalid = rvalid_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;

  always_comb begin
    wea   = 1'b0;
    web   = 1'b0;
    addra = addra_hold_reg;
    addrb = addrb_hold_reg;
    dia   = alu_y;
    dib   = host_wdata;
    case (state_reg)
      ST_RD: begin
        addra = src_a_reg + elem_idx;
        addrb = src_b_reg + elem_idx;
      end
      ST_WR: begin
        wea   = 1'b1;
        addra = dst_reg + elem_idx;
      end
      ST_IDLE: begin
        if (host_gnt) begin
          addrb = host_addr;
          web   = host_we;
        end
      end
      default: ;
    endcase
    // Writes must stop in the very cycle reset is sampled.
    if (rst) begin
      wea = 1'b0;
      web = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      op_reg         <= 3'd0;
      src_a_reg      <= '0;
      src_b_reg      <= '0;
      dst_reg        <= '0;
      len_reg        <= '0;
      idx_reg        <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      rvalid_reg     <= 1'b0;
      addra_hold_reg <= '0;
      addrb_hold_reg <= '0;
    end else begin
      addra_hold_reg <= addra;
      addrb_hold_reg <= addrb;
      done_reg       <= (state_reg == ST_FIN);
      rvalid_reg     <= host_gnt && !host_we;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            op_reg    <= op;
            src_a_reg <= src_a;
            src_b_reg <= src_b;
            dst_reg   <= dst;
            len_reg   <= len;
            idx_reg   <= '0;
            if (len != '0) begin
              state_reg <= ST_RD;
              busy_reg  <= 1'b1;
            end else begin
              state_reg <= ST_FIN;
            end
          end
        end
        ST_RD: begin
          state_reg <= ST_WR;
        end
        ST_WR: begin
          // Element i is committed before element i+1 is read.
          if (last_elem) begin
            state_reg <= ST_FIN;
            busy_reg  <= 1'b0;
          end else begin
            idx_reg   <= idx_reg + LEN_WIDTH'(1);
            state_reg <= ST_RD;
          end
        end
        ST_FIN: begin
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pim_vec_ctrl.sv
// Bench for pim_vec_ctrl: BRAM model plus a per-cycle timeline/memory model.
module tb_pim_vec_ctrl;

  localparam int DW = 16;
  localparam int AW = 6;
  localparam int LW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [AW-1:0] src_a = '0, src_b = '0, dst = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done;
  logic          host_req = 1'b0, host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          wea, web;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dia, dib, doa, dob;

  always #5 clk = ~clk;

  pim_vec_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .dst(dst), .len(len),
    .busy(busy), .done(done),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid),
    .wea(wea), .web(web), .addra(addra), .addrb(addrb),
    .dia(dia), .dib(dib), .doa(doa), .dob(dob)
  );

  // Dual-port BRAM, registered read, read-first.
  logic [DW-1:0] bram [64];
  always @(posedge clk) begin
    if (wea) bram[addra] <= dia;
    if (web) bram[addrb] <= dib;
    doa <= bram[addra];
    dob <= bram[addrb];
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_alu(input logic [2:0] o, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
    logic [31:0] p;
    int sa, sb;
    p  = 32'(a) * 32'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (o)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return p[DW-1:0];
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return a ^ b;
      3'd6: return (sa > sb) ? a : b;
      default: return a;
    endcase
  endfunction

  // Model state: memory image and the currently expected command.
  logic [DW-1:0] ref_mem [64];
  logic [2:0]    m_op;
  logic [AW-1:0] m_sa, m_sb, m_dst;
  int            m_len;
  bit            pend = 1'b0;

  bit            in_op = 1'b0;
  int            k = 0;
  bit            rd_pend = 1'b0;
  logic [DW-1:0] rd_exp;
  logic [AW-1:0] ei, wa;
  logic [DW-1:0] res;
  bit            idle_ok, e_gnt, e_busy, e_done, e_wea, e_web, in_rd;
  int            n2;

  // Per-cycle compare: k counts clock edges since the start-accept edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        chk("rst_wea", 32'(wea), 32'(0));
        chk("rst_web", 32'(web), 32'(0));
        in_op   = 1'b0;
        pend    = 1'b0;
        rd_pend = 1'b0;
      end else begin
        if (pend) begin
          in_op = 1'b1;
          k     = -1;
          pend  = 1'b0;
        end
        n2      = 2 * m_len;
        idle_ok = !in_op || (k < 0) || (k >= n2 + 1);
        e_gnt   = host_req && !start && idle_ok;
        e_busy  = in_op && (k >= 0) && (k < n2);
        e_done  = in_op && (k == n2 + 1);
        e_wea   = e_busy && (k % 2 == 1);
        in_rd   = e_busy && (k % 2 == 0);
        e_web   = e_gnt && host_we;
        chk("gnt", 32'(host_gnt), 32'(e_gnt));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("wea", 32'(wea), 32'(e_wea));
        chk("web", 32'(web), 32'(e_web));
        if (e_wea) begin
          ei  = AW'((k - 1) / 2);
          res = model_alu(m_op, ref_mem[m_sa + ei], ref_mem[m_sb + ei]);
          wa  = m_dst + ei;
          chk("wr_addr", 32'(addra), 32'(wa));
          chk("wr_data", 32'(dia), 32'(res));
          ref_mem[wa] = res;
        end else if (in_rd) begin
          ei = AW'(k / 2);
          wa = m_sa + ei;
          chk("rd_addra", 32'(addra), 32'(wa));
          wa = m_sb + ei;
          chk("rd_addrb", 32'(addrb), 32'(wa));
        end
        if (e_web) begin
          chk("host_addrb", 32'(addrb), 32'(host_addr));
          chk("host_dib", 32'(dib), 32'(host_wdata));
        end
        chk("rvalid", 32'(host_rvalid), 32'(rd_pend));
        if (rd_pend) chk("rdata", 32'(host_rdata), 32'(rd_exp));
        rd_pend = e_gnt && !host_we;
        if (rd_pend) rd_exp = ref_mem[host_addr];
        if (e_web) ref_mem[host_addr] = host_wdata;
        if (in_op) begin
          if (k >= n2 + 1) in_op = 1'b0;
          else k++;
        end
      end
    end
  end

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_req = 1'b0; host_we = 1'b0;
  endtask

  task automatic host_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b0; host_addr = a;
    @(negedge clk);
    host_req = 1'b0;
    #2;
    d = host_rdata;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic [AW-1:0] d, input int n, input bit glitch,
                        input bit hold_req, input int abort_at);
    int cnt;
    bit got;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b; dst = d; len = LW'(n);
    m_op = o; m_sa = a; m_sb = b; m_dst = d; m_len = n; pend = 1'b1;
    if (hold_req) begin
      host_req = 1'b1; host_we = 1'b0; host_addr = a;
      #1;
      chk("gnt_vs_start", 32'(host_gnt), 32'(0));
    end
    cnt = 0;
    got = 1'b0;
    while (cnt < 300 && !got) begin
      @(negedge clk);
      // Scramble command inputs: the DUT must work from captured copies.
      start = 1'b0;
      op    = 3'($urandom);
      src_a = AW'($urandom);
      src_b = AW'($urandom);
      dst   = AW'($urandom);
      len   = LW'($urandom_range(0, 64));
      if (glitch && (cnt == 3 || cnt == 2 * n)) start = 1'b1;
      if (abort_at > 0 && cnt == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      #1;
      if (done) got = 1'b1;
      else cnt++;
    end
    chk("done_seen", 32'(got), 32'(1));
    if (got) chk("done_latency", 32'(cnt), 32'(2 * n + 1));
    if (hold_req) begin
      chk("gnt_after_done", 32'(host_gnt), 32'(1));
      @(negedge clk);
      host_req = 1'b0;
    end
  endtask

  logic [DW-1:0] rd;

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_rvalid", 32'(host_rvalid), 32'(0));
    chk("reset_wea", 32'(wea), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 64; i++) host_write(AW'(i), DW'(i * 1237 + 7));

    // ADD of two 4-element vectors
    for (int i = 0; i < 4; i++) begin
      host_write(AW'(i), DW'(i + 1));
      host_write(AW'(16 + i), DW'(10 * (i + 1)));
    end
    run_op(3'd0, 6'h00, 6'h10, 6'h20, 4, 1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      host_read(AW'(32 + i), rd);
      chk($sformatf("add_%0d", i), 32'(rd), 32'(11 * (i + 1)));
    end

    // Single-element boundary cases
    host_write(6'h30, 16'h0000); host_write(6'h31, 16'h0001);
    run_op(3'd1, 6'h30, 6'h31, 6'h32, 1, 1'b0, 1'b0, 0);
    host_read(6'h32, rd);
    chk("sub_wrap", 32'(rd), 32'h0000FFFF);
    host_write(6'h33, 16'h0100); host_write(6'h34, 16'h0100);
    run_op(3'd2, 6'h33, 6'h34, 6'h35, 1, 1'b0, 1'b0, 0);
    host_read(6'h35, rd);
    chk("mul_low", 32'(rd), 32'h00000000);
    host_write(6'h36, 16'h8000); host_write(6'h37, 16'h0001);
    run_op(3'd6, 6'h36, 6'h37, 6'h38, 1, 1'b0, 1'b0, 0);
    host_read(6'h38, rd);
    chk("max_signed", 32'(rd), 32'h00000001);

    // COPY wrapping past the top into its own destination
    host_write(6'h3E, 16'hAAAA); host_write(6'h3F, 16'hBBBB);
    run_op(3'd7, 6'h3E, 6'h00, 6'h00, 4, 1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      host_read(AW'(i), rd);
      chk($sformatf("copy_%0d", i), 32'(rd), (i % 2 == 0) ? 32'h0000AAAA : 32'h0000BBBB);
    end

    // len=0, starts during busy/FIN, start racing host_req
    run_op(3'd0, 6'h01, 6'h02, 6'h03, 0, 1'b1, 1'b0, 0);
    run_op(3'd4, 6'h10, 6'h20, 6'h28, 4, 1'b1, 1'b0, 0);
    run_op(3'd5, 6'h05, 6'h06, 6'h07, 3, 1'b0, 1'b1, 0);

    // Abort a len=8 op with reset, then run a fresh op
    run_op(3'd0, 6'h08, 6'h18, 6'h28, 8, 1'b0, 1'b0, 5);
    repeat (20) @(negedge clk);
    #2;
    chk("abort_busy", 32'(busy), 32'(0));
    run_op(3'd3, 6'h08, 6'h18, 6'h28, 8, 1'b0, 1'b0, 0);

    // Randomized commands and host traffic
    for (int t = 0; t < 25; t++) begin
      host_write(AW'($urandom), DW'($urandom));
      host_read(AW'($urandom), rd);
      run_op(3'($urandom), AW'($urandom), AW'($urandom), AW'($urandom),
             (t == 5) ? 64 : int'($urandom_range(0, 10)), (t % 4 == 1), (t % 5 == 2), 0);
    end

    for (int i = 0; i < 64; i++) host_read(AW'(i), rd);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
